// File: rtl/dht11_sampler.sv
// Periodic/manual DHT11 measurement sequencer: triggers the sensor controller,
// supervises completion with a timeout and publishes humidity/temperature as BCD.
module dht11_sampler #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned PERIOD_MS  = 2000,
    parameter int unsigned TIMEOUT_US = 30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_auto_en,
    input  logic        i_req,
    input  logic [31:0] i_dht_data,
    input  logic        i_dht_done,
    input  logic        i_dht_valid,
    output logic        o_dht_start,
    output logic [7:0]  o_hum_bcd,
    output logic [7:0]  o_temp_bcd,
    output logic        o_data_ready,
    output logic        o_stale,
    output logic [7:0]  o_err_cnt,
    output logic        o_busy
);

    localparam int unsigned PERIOD_CYC  = CLK_HZ / 1000 * PERIOD_MS;
    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_CONVERT   = 3'd3,
        ST_UPDATE    = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] period_cnt_r;
    logic [31:0] timeout_cnt_r;
    logic [3:0]  conv_cnt_r;
    logic        done_d_r;
    logic        valid_d_r;
    logic [31:0] data_d_r;
    logic [15:0] hum_sr_r;
    logic [15:0] temp_sr_r;
    logic        done_fall_s;
    logic        unused_s;

    // Bytes above 99 cannot be shown in two BCD digits.
    function automatic logic [7:0] clamp99(input logic [7:0] v);
        if (v > 8'd99) begin
            return 8'd99;
        end else begin
            return v;
        end
    endfunction

    // One double-dabble iteration on {tens, ones, binary}: adjust digits, then shift.
    function automatic logic [15:0] dabble_step(input logic [15:0] sr);
        logic [15:0] t;
        t = sr;
        if (t[15:12] >= 4'd5) begin
            t[15:12] = t[15:12] + 4'd3;
        end else begin
            t[15:12] = t[15:12];
        end
        if (t[11:8] >= 4'd5) begin
            t[11:8] = t[11:8] + 4'd3;
        end else begin
            t[11:8] = t[11:8];
        end
        return {t[14:0], 1'b0};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'd255) begin
            return 8'd255;
        end else begin
            return v + 8'd1;
        end
    endfunction

    assign done_fall_s = done_d_r & ~i_dht_done;
    assign o_busy      = (state_r != ST_IDLE);
    // Decimal bytes of the frame are registered but not reported.
    assign unused_s    = ^{data_d_r[23:16], data_d_r[7:0]};

    // Register the sensor-controller handshake and frame every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_d_r  <= 1'b0;
            valid_d_r <= 1'b0;
            data_d_r  <= 32'd0;
        end else begin
            done_d_r  <= i_dht_done;
            valid_d_r <= i_dht_valid;
            data_d_r  <= i_dht_data;
        end
    end

    // Measurement sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            period_cnt_r  <= 32'd0;
            timeout_cnt_r <= 32'd0;
            conv_cnt_r    <= 4'd0;
            hum_sr_r      <= 16'd0;
            temp_sr_r     <= 16'd0;
            o_dht_start   <= 1'b0;
            o_data_ready  <= 1'b0;
            o_hum_bcd     <= 8'd0;
            o_temp_bcd    <= 8'd0;
            o_err_cnt     <= 8'd0;
            o_stale       <= 1'b1;
        end else begin
            o_dht_start  <= 1'b0;
            o_data_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_req || (i_auto_en && (period_cnt_r == PERIOD_LAST))) begin
                        period_cnt_r <= 32'd0;
                        o_dht_start  <= 1'b1;
                        state_r      <= ST_TRIG;
                    end else if (i_auto_en) begin
                        period_cnt_r <= period_cnt_r + 32'd1;
                    end else begin
                        period_cnt_r <= 32'd0;
                    end
                end
                ST_TRIG: begin
                    timeout_cnt_r <= 32'd0;
                    state_r       <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // A completion in the timeout cycle still counts as a completion.
                    if (done_fall_s) begin
                        if (valid_d_r) begin
                            hum_sr_r   <= {8'd0, clamp99(data_d_r[31:24])};
                            temp_sr_r  <= {8'd0, clamp99(data_d_r[15:8])};
                            conv_cnt_r <= 4'd0;
                            state_r    <= ST_CONVERT;
                        end else begin
                            o_err_cnt <= sat_inc(o_err_cnt);
                            o_stale   <= 1'b1;
                            state_r   <= ST_IDLE;
                        end
                    end else if (timeout_cnt_r == TIMEOUT_LAST) begin
                        o_err_cnt <= sat_inc(o_err_cnt);
                        o_stale   <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 32'd1;
                    end
                end
                ST_CONVERT: begin
                    hum_sr_r   <= dabble_step(hum_sr_r);
                    temp_sr_r  <= dabble_step(temp_sr_r);
                    conv_cnt_r <= conv_cnt_r + 4'd1;
                    if (conv_cnt_r == 4'd7) begin
                        state_r <= ST_UPDATE;
                    end else begin
                        state_r <= ST_CONVERT;
                    end
                end
                ST_UPDATE: begin
                    o_hum_bcd    <= hum_sr_r[15:8];
                    o_temp_bcd   <= temp_sr_r[15:8];
                    o_data_ready <= 1'b1;
                    o_stale      <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_sampler.sv
// Directed-plus-random bench for dht11_sampler against a decimal/BCD reference model.
module tb_dht11_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_auto_en = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_dht_data = 32'd0;
    logic        i_dht_done = 1'b0;
    logic        i_dht_valid = 1'b0;
    logic        o_dht_start;
    logic [7:0]  o_hum_bcd;
    logic [7:0]  o_temp_bcd;
    logic        o_data_ready;
    logic        o_stale;
    logic [7:0]  o_err_cnt;
    logic        o_busy;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ready_cnt = 0;
    int          start_q[$];
    int          exp_err = 0;
    logic [7:0]  exp_hum = 8'd0;
    logic [7:0]  exp_temp = 8'd0;
    logic        exp_stale = 1'b1;

    dht11_sampler #(
        .CLK_HZ    (1_000_000),
        .PERIOD_MS (1),
        .TIMEOUT_US(200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_auto_en   (i_auto_en),
        .i_req       (i_req),
        .i_dht_data  (i_dht_data),
        .i_dht_done  (i_dht_done),
        .i_dht_valid (i_dht_valid),
        .o_dht_start (o_dht_start),
        .o_hum_bcd   (o_hum_bcd),
        .o_temp_bcd  (o_temp_bcd),
        .o_data_ready(o_data_ready),
        .o_stale     (o_stale),
        .o_err_cnt   (o_err_cnt),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_dht_start) start_q.push_back(cyc);
        if (o_data_ready) ready_cnt++;
    end

    // Reference: clamp to 0..99, then tens digit in the high nibble, ones in the low.
    function automatic logic [7:0] bcd_of(input logic [7:0] v);
        int c;
        c = (int'(v) > 99) ? 99 : int'(v);
        return 8'((c / 10) * 16 + (c % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/hum"},   32'(o_hum_bcd),  32'(exp_hum));
        chk({tag, "/temp"},  32'(o_temp_bcd), 32'(exp_temp));
        chk({tag, "/err"},   32'(o_err_cnt),  32'(exp_err));
        chk({tag, "/stale"}, 32'(o_stale),    32'(exp_stale));
        chk({tag, "/busy"},  32'(o_busy),     32'd0);
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget && start_q.size() < target; i++) @(negedge clk);
        chk("start_wait", 32'(start_q.size()), 32'(target));
    endtask

    // Manual request, done held high for 'hold' cycles, then done falls.
    task automatic measure(input string tag, input logic [31:0] data, input logic valid,
                           input int hold, input bit poke);
        int s0;
        int r0;
        int lat;
        s0 = start_q.size();
        r0 = ready_cnt;
        lat = 0;
        @(posedge clk); #1 i_req = 1'b1;
        @(posedge clk); #1 i_req = 1'b0;
        i_dht_data  = data;
        i_dht_valid = valid;
        @(posedge clk); #1 i_dht_done = 1'b1;
        if (poke) begin
            @(posedge clk); #1 i_req = 1'b1;
            @(posedge clk); #1 i_req = 1'b0;
        end
        repeat (hold) @(posedge clk);
        #1 i_dht_done = 1'b0;
        i_dht_valid = 1'($urandom_range(0, 1));
        i_dht_data  = $urandom;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_data_ready && lat == 0) lat = i;
        end
        i_dht_valid = 1'b0;
        if (valid) begin
            exp_hum   = bcd_of(data[31:24]);
            exp_temp  = bcd_of(data[15:8]);
            exp_stale = 1'b0;
            chk({tag, "/latency"}, 32'(lat), 32'd10);
            chk({tag, "/ready_pulses"}, 32'(ready_cnt - r0), 32'd1);
        end else begin
            exp_err   = (exp_err < 255) ? exp_err + 1 : 255;
            exp_stale = 1'b1;
            chk({tag, "/ready_pulses"}, 32'(ready_cnt - r0), 32'd0);
        end
        chk({tag, "/start_pulses"}, 32'(start_q.size() - s0), 32'd1);
        check_outputs(tag);
    endtask

    initial begin
        int n0;
        int c_e;
        int r0;
        logic v;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst/start", 32'(o_dht_start), 32'd0);
        chk("rst/ready", 32'(o_data_ready), 32'd0);
        check_outputs("rst");
        rst = 1'b1;

        measure("basic", 32'h3700_1900, 1'b1, 50, 1'b0);
        measure("invalid", 32'h1111_2222, 1'b0, 20, 1'b0);
        measure("clamp", 32'hC800_FF00, 1'b1, 10, 1'b0);
        measure("one_cycle_done", 32'h6300_0000, 1'b1, 1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            v = ($urandom_range(0, 3) != 0);
            measure("random", $urandom, v, $urandom_range(1, 40), 1'b0);
        end
        measure("req_in_wait", 32'h2A00_0500, 1'b1, 8, 1'b1);

        // Auto triggering with the sensor silent: every attempt times out
        @(posedge clk); #1 i_auto_en = 1'b1;
        c_e = cyc;
        n0 = start_q.size();
        wait_starts(n0 + 3, 5000);
        i_auto_en = 1'b0;
        if (start_q.size() >= n0 + 3) begin
            chk("auto/first", 32'(start_q[n0] - c_e), 32'd1000);
            chk("auto/gap1", 32'(start_q[n0 + 1] - start_q[n0]), 32'd1201);
            chk("auto/gap2", 32'(start_q[n0 + 2] - start_q[n0 + 1]), 32'd1201);
        end
        repeat (300) @(posedge clk);
        #1;
        exp_err = exp_err + 3;
        exp_stale = 1'b1;
        check_outputs("auto");

        // Error counter saturation
        for (int k = 0; k < 256; k++) measure("saturate", $urandom, 1'b0, 1, 1'b0);
        chk("err_sat", 32'(o_err_cnt), 32'd255);

        // Reset in the middle of conversion
        r0 = ready_cnt;
        @(posedge clk); #1 i_req = 1'b1;
        @(posedge clk); #1 i_req = 1'b0;
        i_dht_data = 32'h4200_3100;
        i_dht_valid = 1'b1;
        @(posedge clk); #1 i_dht_done = 1'b1;
        repeat (5) @(posedge clk);
        #1 i_dht_done = 1'b0;
        i_dht_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        exp_hum = 8'd0;
        exp_temp = 8'd0;
        exp_err = 0;
        exp_stale = 1'b1;
        chk("midrst/start", 32'(o_dht_start), 32'd0);
        chk("midrst/ready", 32'(o_data_ready), 32'd0);
        check_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        i_auto_en = 1'b1;
        c_e = cyc;
        n0 = start_q.size();
        wait_starts(n0 + 1, 1500);
        i_auto_en = 1'b0;
        chk("midrst/no_ready", 32'(ready_cnt - r0), 32'd0);
        if (start_q.size() >= n0 + 1) begin
            chk("postrst/first", 32'(start_q[n0] - c_e), 32'd1000);
        end
        repeat (300) @(posedge clk);
        #1;
        exp_err = 1;
        check_outputs("postrst_timeout");
        measure("postrst", $urandom, 1'b1, 12, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
